branch_predictor: RTL

Fetch-side producer of the branch prediction interface. Its outputs feed the ID/EX path as i_branch_prediction and i_branch_target_addr, and it consumes the EX-stage branch_taken/mispredicted resolution. It holds a direct-mapped table of 2-bit saturating counters and a FIFO of in-flight predicted branches. On resolution it updates the table and, on a mispredict, drives the corrected fetch PC.

---
 rtl/branch_predictor_if.sv | 32 +++
 rtl/branch_predictor.sv | 115 +++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Branch prediction bundle between fetch/execute and the predictor.
// The master drives IF lookups and EX resolutions; the slave predicts.
interface branch_predictor_if;
    logic        i_stall;
    logic [31:0] i_if_pc;
    logic        i_if_is_branch;
    logic [15:0] i_if_imm;
    logic        i_flush;
    logic        i_ex_branch;
    logic        i_ex_branch_taken;
    logic        i_ex_mispredicted;
    logic        o_prediction;
    logic [31:0] o_target_addr;
    logic        o_stall_req;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_underflow;

    modport master (
        output i_stall, i_if_pc, i_if_is_branch, i_if_imm, i_flush,
        output i_ex_branch, i_ex_branch_taken, i_ex_mispredicted,
        input  o_prediction, o_target_addr, o_stall_req,
        input  o_redirect, o_redirect_pc, o_underflow
    );

    modport slave (
        input  i_stall, i_if_pc, i_if_is_branch, i_if_imm, i_flush,
        input  i_ex_branch, i_ex_branch_taken, i_ex_mispredicted,
        output o_prediction, o_target_addr, o_stall_req,
        output o_redirect, o_redirect_pc, o_underflow
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter BHT plus a FIFO of
// in-flight predicted branches resolved in order by EX.
module branch_predictor #(
    parameter int BHT_INDEX_BITS = 6,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int BHT_SIZE = 1 << BHT_INDEX_BITS;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef logic [BHT_INDEX_BITS-1:0] idx_t;

    typedef struct packed {
        idx_t        idx;
        logic        pred;
        logic [31:0] pc4;
        logic [31:0] target;
    } entry_t;

    logic [1:0]    bht_q  [BHT_SIZE];
    logic [1:0]    bht_d  [BHT_SIZE];
    entry_t        fifo_q [FIFO_DEPTH];
    entry_t        fifo_d [FIFO_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;

    idx_t        if_idx;
    logic [31:0] if_pc4;
    logic [31:0] if_target;
    logic        if_pred;
    entry_t      head;
    logic [1:0]  head_ctr;
    logic        nonempty, full, pop, redirect, clear, push;

    always_comb begin
        if_idx    = bp.i_if_pc[BHT_INDEX_BITS+1:2];
        if_pc4    = bp.i_if_pc + 32'd4;
        if_target = if_pc4 + {{14{bp.i_if_imm[15]}}, bp.i_if_imm, 2'b00};
        if_pred   = bp.i_if_is_branch & bht_q[if_idx][1];
        head      = fifo_q[head_q];
        head_ctr  = bht_q[head.idx];
        nonempty  = (count_q != '0);
        full      = (count_q == FULL);
        pop       = bp.i_ex_branch & nonempty;
        redirect  = pop & bp.i_ex_mispredicted;
        // Redirect and flush both squash everything younger than EX.
        clear     = bp.i_flush | redirect;
        push      = bp.i_if_is_branch & ~bp.i_stall & ~full & ~clear;
    end

    assign bp.o_prediction  = if_pred;
    assign bp.o_target_addr = if_target;
    assign bp.o_stall_req   = full;
    assign bp.o_redirect    = redirect;
    assign bp.o_redirect_pc = bp.i_ex_branch_taken ? head.target : head.pc4;
    assign bp.o_underflow   = underflow_q;

    always_comb begin
        bht_d       = bht_q;
        fifo_d      = fifo_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        underflow_d = underflow_q | (bp.i_ex_branch & ~nonempty);

        if (pop) begin
            unique case (1'b1)
                bp.i_ex_branch_taken && head_ctr != 2'b11:
                    bht_d[head.idx] = head_ctr + 2'd1;
                !bp.i_ex_branch_taken && head_ctr != 2'b00:
                    bht_d[head.idx] = head_ctr - 2'd1;
                default: ;
            endcase
        end

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fifo_d[tail_q] = '{idx: if_idx, pred: if_pred,
                                   pc4: if_pc4, target: if_target};
                tail_d = tail_q + 1'b1;
            end
            if (pop) head_d = head_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_SIZE; i++) bht_q[i] <= 2'b01;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            bht_q       <= bht_d;
            fifo_q      <= fifo_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end
endmodule
